// File: rtl/jtsdram_pkg.sv
// Shared definitions for the SDRAM test statistics collector.
package jtsdram_pkg;

  localparam int NBANK = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PROG = 2'd1,
    RUN  = 2'd2,
    FAIL = 2'd3
  } state_t;

  localparam logic [2:0] A_STATUS = 3'd0;
  localparam logic [2:0] A_ERR0   = 3'd1;
  localparam logic [2:0] A_ERR1   = 3'd2;
  localparam logic [2:0] A_ERR2   = 3'd3;
  localparam logic [2:0] A_ERR3   = 3'd4;
  localparam logic [2:0] A_FRM_LO = 3'd5;
  localparam logic [2:0] A_FRM_HI = 3'd6;
  localparam logic [2:0] A_FIRST  = 3'd7;

  // Index of the lowest set bit; zero when nothing is set.
  function automatic logic [1:0] low_bank(input logic [NBANK-1:0] v);
    logic [1:0] r;
    r = 2'd0;
    for (int i = NBANK - 1; i >= 0; i--) begin
      if (v[i]) r = i[1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/jtsdram_edge.sv
// Single-bit edge detector against a registered copy of the input.
module jtsdram_edge #(
  parameter logic FALL    = 1'b0,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic q;

  // Previous-cycle copy of the input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= RST_VAL;
    else        q <= din;
  end

  assign pulse = FALL ? (q & ~din) : (din & ~q);

endmodule

// File: rtl/jtsdram_stats.sv
// Run statistics for the SDRAM checker: per-bank error counters, sticky
// fail flags, frame time, first-failure record, status LED and read port.
module jtsdram_stats
  import jtsdram_pkg::*;
#(
  parameter int SLOW_BLINK = 5,
  parameter int FAST_BLINK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             LVBL,
  input  logic             dwnld_busy,
  input  logic [NBANK-1:0] ba_bad,
  input  logic             clr,
  input  logic [2:0]       rd_addr,
  output logic [7:0]       rd_data,
  output logic [NBANK-1:0] sticky,
  output logic             any_bad,
  output logic             led
);

  state_t           state, state_nxt;
  logic [7:0]       err_cnt [NBANK];
  logic [15:0]      frames;
  logic [7:0]       blink_cnt, blink_nxt;
  logic             first_vld;
  logic [1:0]       first_bank;
  logic [4:0]       first_frame;
  logic [NBANK-1:0] bad_rise, ev;
  logic             frame_tick, counting, wipe, led_nxt;
  logic [7:0]       rd_mux;

  for (genvar n = 0; n < NBANK; n++) begin : g_bad
    jtsdram_edge #(.FALL(1'b0), .RST_VAL(1'b0)) u_bad (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (ba_bad[n]),
      .pulse (bad_rise[n])
    );
  end

  // LVBL idles high, so its history starts high to avoid a false frame.
  jtsdram_edge #(.FALL(1'b1), .RST_VAL(1'b1)) u_lvbl (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (LVBL),
    .pulse (frame_tick)
  );

  assign counting = (state == RUN) || (state == FAIL);
  assign ev       = counting ? bad_rise : '0;
  assign wipe     = clr | dwnld_busy;
  assign any_bad  = |sticky;
  assign blink_nxt = blink_cnt + {7'd0, frame_tick};

  // Next state and the LED value that goes with it.
  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = IDLE;
    end else if (dwnld_busy) begin
      state_nxt = PROG;
    end else begin
      case (state)
        IDLE:    state_nxt = RUN;
        PROG:    state_nxt = RUN;
        RUN:     state_nxt = (|ev) ? FAIL : RUN;
        default: state_nxt = FAIL;
      endcase
    end
    case (state_nxt)
      PROG:    led_nxt = 1'b1;
      RUN:     led_nxt = blink_nxt[SLOW_BLINK];
      FAIL:    led_nxt = blink_nxt[FAST_BLINK];
      default: led_nxt = 1'b0;
    endcase
  end

  // Sequencer state, LED and free-running blink counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      led       <= 1'b0;
      blink_cnt <= 8'd0;
    end else begin
      state     <= state_nxt;
      led       <= led_nxt;
      blink_cnt <= blink_nxt;
    end
  end

  // Statistics; clear and programming wipe everything before any update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NBANK; n++) err_cnt[n] <= 8'd0;
      sticky      <= '0;
      frames      <= 16'd0;
      first_vld   <= 1'b0;
      first_bank  <= 2'd0;
      first_frame <= 5'd0;
    end else if (wipe) begin
      for (int n = 0; n < NBANK; n++) err_cnt[n] <= 8'd0;
      sticky      <= '0;
      frames      <= 16'd0;
      first_vld   <= 1'b0;
      first_bank  <= 2'd0;
      first_frame <= 5'd0;
    end else begin
      for (int n = 0; n < NBANK; n++) begin
        if (ev[n]) begin
          sticky[n] <= 1'b1;
          if (err_cnt[n] != 8'hFF) err_cnt[n] <= err_cnt[n] + 8'd1;
        end
      end
      if (counting && frame_tick && (frames != 16'hFFFF)) frames <= frames + 16'd1;
      if ((|ev) && !first_vld) begin
        first_vld   <= 1'b1;
        first_bank  <= low_bank(ev);
        first_frame <= frames[4:0];
      end
    end
  end

  // Read map selection.
  always_comb begin
    rd_mux = 8'd0;
    case (rd_addr)
      A_STATUS: rd_mux = {state, 2'b00, sticky};
      A_ERR0:   rd_mux = err_cnt[0];
      A_ERR1:   rd_mux = err_cnt[1];
      A_ERR2:   rd_mux = err_cnt[2];
      A_ERR3:   rd_mux = err_cnt[3];
      A_FRM_LO: rd_mux = frames[7:0];
      A_FRM_HI: rd_mux = frames[15:8];
      default:  rd_mux = {first_vld, first_bank, first_frame};
    endcase
  end

  // Registered read port, one cycle behind the address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= 8'd0;
    else        rd_data <= rd_mux;
  end

endmodule

// File: tb/tb_jtsdram_stats.sv
// Directed bench for jtsdram_stats: a per-cycle vector table for the
// basic flow plus hand-written sequences for the multi-cycle corners.
module tb_jtsdram_stats;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       lvbl, busy, clr;
  logic [3:0] bad;
  logic [2:0] addr;
  logic [7:0] rd_data;
  logic [3:0] sticky;
  logic       any_bad, led;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  jtsdram_stats #(.SLOW_BLINK(5), .FAST_BLINK(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .LVBL       (lvbl),
    .dwnld_busy (busy),
    .ba_bad     (bad),
    .clr        (clr),
    .rd_addr    (addr),
    .rd_data    (rd_data),
    .sticky     (sticky),
    .any_bad    (any_bad),
    .led        (led)
  );

  typedef struct packed {
    logic [3:0] bad;
    logic       lvbl;
    logic       busy;
    logic       clr;
    logic [2:0] addr;
    logic [7:0] exp_rd;
    logic [3:0] exp_sticky;
    logic       exp_led;
  } vec_t;

  localparam int NVEC = 25;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic [3:0] b, input logic l, input logic bz,
                              input logic c, input logic [2:0] a, input logic [7:0] r,
                              input logic [3:0] s, input logic ld);
    vec_t v;
    v.bad = b; v.lvbl = l; v.busy = bz; v.clr = c; v.addr = a;
    v.exp_rd = r; v.exp_sticky = s; v.exp_led = ld;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic cyc(input logic [3:0] b, input logic l, input logic bz,
                     input logic c, input logic [2:0] a);
    bad = b; lvbl = l; busy = bz; clr = c; addr = a;
    @(negedge clk);
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] exp, input string name);
    addr = a;
    @(negedge clk);
    check(name, {8'd0, rd_data}, {8'd0, exp});
  endtask

  initial begin
    rst_n = 1'b0; lvbl = 1'b1; busy = 1'b0; clr = 1'b0; bad = 4'h0; addr = 3'd0;

    // v: bad lvbl busy clr addr | rd sticky led
    vecs[0]  = mk(4'h0, 1, 1, 0, 3'd0, 8'h00, 4'h0, 1);
    vecs[1]  = mk(4'h0, 1, 1, 0, 3'd0, 8'h40, 4'h0, 1);
    vecs[2]  = mk(4'h0, 1, 0, 0, 3'd0, 8'h40, 4'h0, 0);
    vecs[3]  = mk(4'h0, 1, 0, 0, 3'd0, 8'h80, 4'h0, 0);
    vecs[4]  = mk(4'h0, 0, 0, 0, 3'd5, 8'h00, 4'h0, 0);
    vecs[5]  = mk(4'h0, 1, 0, 0, 3'd5, 8'h01, 4'h0, 0);
    vecs[6]  = mk(4'h0, 0, 0, 0, 3'd5, 8'h01, 4'h0, 0);
    vecs[7]  = mk(4'h0, 1, 0, 0, 3'd5, 8'h02, 4'h0, 0);
    vecs[8]  = mk(4'h0, 0, 0, 0, 3'd5, 8'h02, 4'h0, 0);
    vecs[9]  = mk(4'h0, 1, 0, 0, 3'd5, 8'h03, 4'h0, 0);
    vecs[10] = mk(4'h0, 1, 0, 0, 3'd0, 8'h80, 4'h0, 0);
    vecs[11] = mk(4'h4, 1, 0, 0, 3'd3, 8'h00, 4'h4, 0);
    vecs[12] = mk(4'h0, 1, 0, 0, 3'd3, 8'h01, 4'h4, 0);
    vecs[13] = mk(4'h4, 1, 0, 0, 3'd3, 8'h01, 4'h4, 0);
    vecs[14] = mk(4'h0, 1, 0, 0, 3'd3, 8'h02, 4'h4, 0);
    vecs[15] = mk(4'h4, 1, 0, 0, 3'd3, 8'h02, 4'h4, 0);
    vecs[16] = mk(4'h0, 1, 0, 0, 3'd3, 8'h03, 4'h4, 0);
    vecs[17] = mk(4'h4, 1, 0, 0, 3'd3, 8'h03, 4'h4, 0);
    vecs[18] = mk(4'h0, 1, 0, 0, 3'd3, 8'h04, 4'h4, 0);
    vecs[19] = mk(4'h4, 1, 0, 0, 3'd3, 8'h04, 4'h4, 0);
    vecs[20] = mk(4'h0, 1, 0, 0, 3'd3, 8'h05, 4'h4, 0);
    vecs[21] = mk(4'h0, 1, 0, 0, 3'd0, 8'hC4, 4'h4, 0);
    vecs[22] = mk(4'h0, 1, 0, 0, 3'd7, 8'hC3, 4'h4, 0);
    vecs[23] = mk(4'h0, 0, 0, 0, 3'd5, 8'h03, 4'h4, 1);
    vecs[24] = mk(4'h0, 1, 0, 0, 3'd5, 8'h04, 4'h4, 1);

    // Reset values
    @(negedge clk);
    check("rst_rd_data", {8'd0, rd_data}, 16'h0);
    check("rst_sticky", {12'd0, sticky}, 16'h0);
    check("rst_any_bad", {15'd0, any_bad}, 16'h0);
    check("rst_led", {15'd0, led}, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Programming, run, frames and bank 2 errors
    for (int i = 0; i < NVEC; i++) begin
      cyc(vecs[i].bad, vecs[i].lvbl, vecs[i].busy, vecs[i].clr, vecs[i].addr);
      check($sformatf("vec%0d_rd", i), {8'd0, rd_data}, {8'd0, vecs[i].exp_rd});
      check($sformatf("vec%0d_sticky", i), {12'd0, sticky}, {12'd0, vecs[i].exp_sticky});
      check($sformatf("vec%0d_any_bad", i), {15'd0, any_bad}, {15'd0, |vecs[i].exp_sticky});
      check($sformatf("vec%0d_led", i), {15'd0, led}, {15'd0, vecs[i].exp_led});
    end

    // Bank 0 held high counts once, then saturates under many pulses
    for (int i = 0; i < 100; i++) cyc(4'h1, 1, 0, 0, 3'd1);
    bad = 4'h0;
    rd(3'd1, 8'h01, "hold_once");
    for (int i = 0; i < 300; i++) begin
      cyc(4'h1, 1, 0, 0, 3'd1);
      cyc(4'h0, 1, 0, 0, 3'd1);
    end
    rd(3'd1, 8'hFF, "err0_saturate");
    rd(3'd0, 8'hC5, "status_after_bank0");
    rd(3'd7, 8'hC3, "first_record_kept");

    // Clear, then simultaneous edges on banks 1 and 3
    cyc(4'h0, 1, 0, 1, 3'd0);
    cyc(4'h0, 1, 0, 0, 3'd0);
    cyc(4'hA, 1, 0, 0, 3'd0);
    rd(3'd2, 8'h01, "dual_err1");
    rd(3'd4, 8'h01, "dual_err3");
    rd(3'd7, 8'hA0, "dual_first_bank1");
    rd(3'd0, 8'hCA, "dual_status");
    rd(3'd1, 8'h00, "clr_wiped_err0");

    // Clear in the same cycle as a bank 1 edge
    cyc(4'h0, 1, 0, 0, 3'd0);
    cyc(4'h2, 1, 0, 1, 3'd0);
    check("clr_edge_sticky", {12'd0, sticky}, 16'h0);
    check("clr_edge_any_bad", {15'd0, any_bad}, 16'h0);
    cyc(4'h2, 1, 0, 0, 3'd0);
    check("clr_idle_one_cycle", {8'd0, rd_data}, 16'h00);
    cyc(4'h2, 1, 0, 0, 3'd0);
    check("clr_then_run", {8'd0, rd_data}, 16'h80);
    rd(3'd2, 8'h00, "clr_edge_err1");

    // Programming during FAIL wipes the statistics
    cyc(4'h0, 1, 0, 0, 3'd0);
    cyc(4'h8, 1, 0, 0, 3'd0);
    check("refail_sticky", {12'd0, sticky}, 16'h8);
    cyc(4'h0, 1, 1, 0, 3'd0);
    check("prog_led", {15'd0, led}, 16'h1);
    check("prog_sticky", {12'd0, sticky}, 16'h0);
    rd(3'd0, 8'h40, "prog_status");
    rd(3'd4, 8'h00, "prog_err3");
    cyc(4'h0, 1, 0, 0, 3'd0);

    // Frame counter saturation
    force dut.frames = 16'hFFFE;
    #1;
    release dut.frames;
    for (int i = 0; i < 4; i++) begin
      cyc(4'h0, 0, 0, 0, 3'd5);
      cyc(4'h0, 1, 0, 0, 3'd5);
    end
    rd(3'd5, 8'hFF, "frames_lo_sat");
    rd(3'd6, 8'hFF, "frames_hi_sat");

    // Asynchronous reset mid-run
    cyc(4'h1, 1, 0, 0, 3'd0);
    cyc(4'h0, 1, 0, 0, 3'd0);
    check("pre_reset_status", {8'd0, rd_data}, 16'hC1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rd_data", {8'd0, rd_data}, 16'h0);
    check("async_sticky", {12'd0, sticky}, 16'h0);
    check("async_any_bad", {15'd0, any_bad}, 16'h0);
    check("async_led", {15'd0, led}, 16'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/jtsdram_stats.md
# jtsdram_stats

Result collector downstream of the SDRAM checker. Consumes the per-bank `bad` flags, `dwnld_busy` and `LVBL`, and keeps the run statistics: sticky per-bank fail flags, saturating error-event counters, a frame counter of test time, and the first failing bank and frame. Exposes everything through a small registered read port for the on-screen status logic, and drives a status LED pattern.

## Interface
Parameters:
- `SLOW_BLINK`, 5, log2 of frames per LED toggle when passing (32 frames).
- `FAST_BLINK`, 2, log2 of frames per LED toggle after a failure (4 frames).

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `LVBL`  in  1  vertical blank, active low; a falling edge marks one frame.
- `dwnld_busy`  in  1  checker is programming the SDRAM.
- `ba_bad`  in  4  per-bank bad flags, bit n = bank n.
- `clr`  in  1  synchronous clear of all statistics, one-cycle pulse.
- `rd_addr`  in  3  read-port address.
- `rd_data`  out  8  registered read data.
- `sticky`  out  4  per-bank fail flag, set on the first error, held until `clr`.
- `any_bad`  out  1  OR of `sticky`.
- `led`  out  1  status LED.

## Operation
- State machine, encoding 2 bits:
  - IDLE=0. After reset or `clr`.
  - PROG=1. Entered from any state when `dwnld_busy`=1.
  - RUN=2. PROG→RUN when `dwnld_busy` falls.
  - FAIL=3. RUN→FAIL when any error is counted.
- IDLE→RUN directly if `dwnld_busy`=0 in IDLE.
- `clr` forces IDLE and has priority over every other transition and update.
- On entering PROG, all counters, sticky flags and the first-fail record are cleared.
- Error event: a rising edge on `ba_bad[n]`, detected against a registered copy `bad_q`. It counts only in RUN or FAIL.
  - `err_cnt[n]`: 8 bits, increments per event, saturates at 255.
  - `sticky[n]` is set on the event.
- First-fail record:
  - On the first event after clear, latch `first_bank` (lowest index among the banks with an edge that cycle), `first_vld`=1, and `first_frame` = current `frames`.
  - Later events do not update the record.
- `frames`: 16 bits, increments on each `LVBL` falling edge in RUN or FAIL, saturates at 0xFFFF.
- `blink_cnt`: free-running 8-bit frame counter, counts in all states.
- LED:
  - PROG: constant 1.
  - IDLE: constant 0.
  - RUN: `blink_cnt[SLOW_BLINK]`.
  - FAIL: `blink_cnt[FAST_BLINK]`.
- Read map for `rd_data`:
  - 0: {state, 2'b00, sticky}
  - 1–4: `err_cnt[0..3]`
  - 5: `frames[7:0]`
  - 6: `frames[15:8]`
  - 7: {first_vld, first_bank, first_frame[4:0]}

## Timing
- Reset values: all outputs 0, state IDLE, `bad_q`=0, LVBL edge register=1.
- Edge detection: the input is high at edge k and `bad_q` was low. Counter, `sticky` and state update at edge k and are visible after edge k.
- `rd_data` latency is 1 cycle from `rd_addr`. It reflects the register contents after the previous edge.
- Simultaneous events:
  - Edges on several banks in one cycle each count once.
  - An edge in the same cycle as the `dwnld_busy` fall is not counted, because state is still PROG.
  - `clr` together with an edge: `clr` wins and the count stays 0.
- `ba_bad` held high counts once. It counts again only after it drops and rises again.
- Reset mid-run: immediate asynchronous return to the reset values.

## Structure
- Shared package `jtsdram_pkg`:
  - state encoding constants IDLE, PROG, RUN, FAIL.
  - read-map address constants.
  - `NBANK`=4.
- One natural sub-module, `jtsdram_edge`: rising/falling edge detector with registered input, instantiated for `LVBL` and for each `ba_bad` bit.
- Counter saturation and the read mux are inline.

## Test plan
- Reset, then `dwnld_busy` 1→0, then 3 LVBL frames with no errors. Required: addr0=0x80 (RUN), addr5=3, `led`=0 while `blink_cnt` < 32, `any_bad`=0.
- In RUN, pulse `ba_bad[2]` five times. Required: addr3=5, `sticky`=4'b0100, state FAIL (addr0=0xC4), addr7 = {1, 2'd2, frames[4:0]}.
- Hold `ba_bad[0]` high for 100 cycles. Required: addr1=1. Then apply 300 separate pulses. Required: addr1=255 (saturated).
- In one cycle, raise `ba_bad[1]` and `ba_bad[3]`. Required: both counters=1, `first_bank`=1.
- Pulse `ba_bad[1]` in the same cycle as `clr`. Required: all counters 0, state IDLE for 1 cycle, then RUN. Assert `dwnld_busy` mid-FAIL. Required: statistics cleared and `led`=1.
- Force `frames` near 0xFFFE, then apply 4 frames. Required: addr5/addr6 = 0xFF/0xFF. Assert `rst_n` low mid-run. Required: all outputs 0 asynchronously, before the next clk edge.
